// File: rtl/core_req_pkg.sv
// Purpose: shared types for the core request engine (opcodes, FSM states, command layout).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package core_req_pkg;

  // Default field widths of a queued command (match the engine's default parameters)
  localparam int CMD_ADDR_W  = 32;
  localparam int CMD_DATA_W  = 8;
  localparam int CMD_DELAY_W = 8;

  // Command opcodes as carried on cmd_op; code 3 is reserved and consumed as a no-op
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DELAY = 2'd2
  } state_e;

  // Command layout at default widths, for sequencers that build commands in software-like code
  typedef struct packed {
    op_e                    op;
    logic [CMD_ADDR_W-1:0]  addr;
    logic [CMD_DATA_W-1:0]  data;
    logic [CMD_DELAY_W-1:0] delay;
  } cmd_t;

  // True for opcodes that produce a cache request; NOP is popped and dropped
  function automatic logic op_issues(input op_e op);
    return (op != OP_NOP);
  endfunction

endpackage

// File: rtl/core_cmd_fifo.sv
// Purpose: circular command buffer of DEPTH entries holding an arbitrary packed type.
// Latency: push visible at the head one cycle after the push edge; head read combinationally.
// Backpressure: full is derived from the registered count only; no same-cycle bypass when full.
module core_cmd_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_dat,
  input  logic                     pop,
  output T                         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);

endmodule

// File: rtl/core_req_engine.sv
// Purpose: queues READ/WRITE/FLUSH commands and issues them one at a time to a cache core port; optional read-data checking under CORE_REQ_CHECK_EN.
// Latency: command into an empty queue at edge E drives req_valid after E+1; after a handshake req_valid stays low cmd_delay+1 cycles.
// Backpressure: cmd_ready = !full from the registered count; the request is held stable until req_ready.
module core_req_engine
  import core_req_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int DELAY_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  input  logic [DELAY_W-1:0] cmd_delay,
  output logic               req_valid,
  output logic               req_write,
  output logic               req_flush_all,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  input  logic               req_ready,
  input  logic [DATA_W-1:0]  req_rdata,
  output logic               rsp_valid,
  output logic [ADDR_W-1:0]  rsp_addr,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               busy,
  output logic [CNT_W-1:0]   issued_cnt,
  output logic               err_valid,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int FCNT_W = $clog2(DEPTH) + 1;

  // Command layout at this instance's widths
  typedef struct packed {
    op_e                op;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [DELAY_W-1:0] delay;
  } req_cmd_t;

  state_e             state_q;
  state_e             state_d;
  req_cmd_t           fifo_in;
  req_cmd_t           fifo_head;
  req_cmd_t           cur_q;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FCNT_W-1:0]  fifo_count;
  logic [DELAY_W-1:0] dly_q;
  logic               in_issue;
  logic               complete;
  logic               cur_is_read;

  assign fifo_in = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_data, delay: cmd_delay};

  core_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (req_cmd_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: pop in IDLE, wait for the handshake in ISSUE, count out the idle gap in DELAY
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && op_issues(fifo_head.op)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (req_ready) state_d = (cur_q.delay != '0) ? ST_DELAY : ST_IDLE;
      end
      ST_DELAY: begin
        if (dly_q <= DELAY_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and strobes: request fields are only driven while a request is outstanding
  always_comb begin
    in_issue      = (state_q == ST_ISSUE);
    complete      = in_issue && req_ready;
    cur_is_read   = (cur_q.op == OP_READ);
    fifo_pop      = (state_q == ST_IDLE) && !fifo_empty;
    cmd_ready     = !fifo_full;
    fifo_push     = cmd_valid && !fifo_full;
    req_valid     = in_issue;
    req_write     = in_issue && (cur_q.op == OP_WRITE);
    req_flush_all = in_issue && (cur_q.op == OP_FLUSH);
    req_addr      = in_issue ? cur_q.addr : '0;
    req_wdata     = (in_issue && (cur_q.op == OP_WRITE)) ? cur_q.data : '0;
    busy          = (state_q != ST_IDLE) || (fifo_count != '0);
  end

  // Datapath: latch popped command, run the gap counter, count handshakes, capture read returns
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= '0;
      dly_q      <= '0;
      issued_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_addr   <= '0;
      rsp_rdata  <= '0;
    end else begin
      if (fifo_pop) cur_q <= fifo_head;

      if (complete)                    dly_q <= cur_q.delay;
      else if (state_q == ST_DELAY)    dly_q <= dly_q - DELAY_W'(1);

      if (complete && (issued_cnt != {CNT_W{1'b1}}))
        issued_cnt <= issued_cnt + CNT_W'(1);

      rsp_valid <= complete && cur_is_read;
      if (complete && cur_is_read) begin
        rsp_addr  <= cur_q.addr;
        rsp_rdata <= req_rdata;
      end
    end
  end

`ifdef CORE_REQ_CHECK_EN
  logic rd_mismatch;
  assign rd_mismatch = complete && cur_is_read && (req_rdata != cur_q.data);

  // Flag read data that differs from the value queued with the command
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_valid <= rd_mismatch;
      if (rd_mismatch && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`else
  assign err_valid = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_core_req_engine.sv
// Purpose: directed self-checking bench for core_req_engine with request/response scoreboards.
// Latency: n/a.
// Backpressure: bench drives req_ready per step.
module tb_core_req_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_delay;
  logic        req_valid;
  logic        req_write;
  logic        req_flush_all;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic [7:0]  rdata_drv;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [7:0]  rsp_rdata;
  logic        busy;
  logic [15:0] issued_cnt;
  logic        err_valid;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  core_req_engine dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_delay(cmd_delay),
    .req_valid(req_valid), .req_write(req_write), .req_flush_all(req_flush_all),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(rdata_drv),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .busy(busy), .issued_cnt(issued_cnt), .err_valid(err_valid), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); end end

  typedef struct { logic w; logic f; logic [31:0] a; logic [7:0] d; } exp_req_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } exp_rsp_t;

  exp_req_t exp_req[$];
  exp_rsp_t exp_rsp[$];
  exp_req_t mon_req;
  exp_rsp_t mon_rsp;

  int vld_cycles = 0;
  int rsp_cycles = 0;
  int err_cycles = 0;
  int last_hs_cyc = -1;
  int last_gap = -1;
  logic prev_vld = 1'b0;
  logic prev_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops scoreboards on handshakes/responses, tracks gaps and bubbles
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
      prev_hs = 1'b0;
      last_hs_cyc = -1;
    end else begin
      if (prev_hs) `CHK("bubble_after_hs", req_valid, 1'b0)
      if (req_valid === 1'b1 && !prev_vld && last_hs_cyc >= 0) last_gap = cyc - last_hs_cyc - 1;
      if (req_valid === 1'b1) vld_cycles++;
      if (err_valid === 1'b1) begin
        err_cycles++;
        `CHK("err_with_rsp", rsp_valid, 1'b1)
      end
      if (rsp_valid === 1'b1) begin
        rsp_cycles++;
        `CHK("rsp_timing", cyc, last_hs_cyc + 1)
        `CHK("rsp_expected", exp_rsp.size() > 0, 1'b1)
        if (exp_rsp.size() > 0) begin
          mon_rsp = exp_rsp.pop_front();
          `CHK("rsp_addr", rsp_addr, mon_rsp.a)
          `CHK("rsp_rdata", rsp_rdata, mon_rsp.d)
        end
      end
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        `CHK("req_expected", exp_req.size() > 0, 1'b1)
        if (exp_req.size() > 0) begin
          mon_req = exp_req.pop_front();
          `CHK("req_write", req_write, mon_req.w)
          `CHK("req_flush_all", req_flush_all, mon_req.f)
          `CHK("req_addr", req_addr, mon_req.a)
          if (mon_req.w) `CHK("req_wdata", req_wdata, mon_req.d)
        end
        last_hs_cyc = cyc;
      end
      prev_hs = (req_valid === 1'b1) && (req_ready === 1'b1);
      prev_vld = (req_valid === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [7:0] d, input logic [7:0] dl);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_delay = dl;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_req(input logic w, input logic f, input logic [31:0] a, input logic [7:0] d);
    exp_req_t e;
    e.w = w; e.f = f; e.a = a; e.d = d;
    exp_req.push_back(e);
  endtask

  task automatic expect_rsp(input logic [31:0] a, input logic [7:0] d);
    exp_rsp_t e;
    e.a = a; e.d = d;
    exp_rsp.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, busy, 1'b0)
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_req.delete();
    exp_rsp.delete();
  endtask

  task automatic zero_counters();
    vld_cycles = 0; rsp_cycles = 0; err_cycles = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_delay = '0;
    req_ready = 1'b0; rdata_drv = '0;
    tick(); tick(); tick();
    `CHK("reset_cmd_ready", cmd_ready, 1'b1)
    `CHK("reset_req_valid", req_valid, 1'b0)
    `CHK("reset_busy", busy, 1'b0)
    `CHK("reset_issued", issued_cnt, 16'd0)
    `CHK("reset_rsp_valid", rsp_valid, 1'b0)
    `CHK("reset_req_addr", req_addr, 32'd0)
    `CHK("reset_err_cnt", err_cnt, 16'd0)
    rst = 1'b0;

    // WRITE with ready tied high: single-cycle request, no response
    req_ready = 1'b1; zero_counters();
    expect_req(1'b1, 1'b0, 32'h1000, 8'hA5);
    push_cmd(2'd1, 32'h1000, 8'hA5, 8'd0);
    @(negedge clk);
    `CHK("t1_lat_before", req_valid, 1'b0)
    @(negedge clk);
    `CHK("t1_lat_after", req_valid, 1'b1)
    wait_idle(20, "t1_idle");
    tick(); tick();
    `CHK("t1_vld_cycles", vld_cycles, 1)
    `CHK("t1_rsp_cycles", rsp_cycles, 0)
    `CHK("t1_issued", issued_cnt, 16'd1)
    `CHK("t1_sb_empty", exp_req.size(), 0)

    // READ held off for 5 cycles then returned
    zero_counters(); req_ready = 1'b0; rdata_drv = 8'h3C;
    expect_req(1'b0, 1'b0, 32'h2004, 8'h00);
    expect_rsp(32'h2004, 8'h3C);
    push_cmd(2'd0, 32'h2004, 8'h3C, 8'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (req_valid !== 1'b1 && n < 20);
    `CHK("t2_req_seen", req_valid, 1'b1)
    for (int i = 0; i < 5; i++) begin
      `CHK("t2_hold_valid", req_valid, 1'b1)
      `CHK("t2_hold_addr", req_addr, 32'h2004)
      `CHK("t2_hold_write", req_write, 1'b0)
      tick();
    end
    req_ready = 1'b1;
    wait_idle(20, "t2_idle");
    tick(); tick();
    `CHK("t2_vld_cycles", vld_cycles, 6)
    `CHK("t2_rsp_cycles", rsp_cycles, 1)
    `CHK("t2_err_cycles", err_cycles, 0)
    `CHK("t2_issued", issued_cnt, 16'd2)
    `CHK("t2_rsp_sb_empty", exp_rsp.size(), 0)

    // Overflow: 12 offered with the cache stalled, 9 accepted, order preserved
    do_reset(); req_ready = 1'b0; zero_counters(); acc = 0;
    for (int i = 0; i < 9; i++) expect_req(1'b1, 1'b0, 32'h100 + i, 8'h10 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 32'h100 + i; cmd_data = 8'h10 + 8'(i); cmd_delay = 8'd0;
      @(negedge clk);
      if (cmd_ready === 1'b1) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    `CHK("t3_accepted", acc, 9)
    `CHK("t3_ready_low", cmd_ready, 1'b0)
    `CHK("t3_busy", busy, 1'b1)
    req_ready = 1'b1;
    wait_idle(100, "t3_idle");
    tick(); tick();
    `CHK("t3_issued", issued_cnt, 16'd9)
    `CHK("t3_sb_empty", exp_req.size(), 0)
    `CHK("t3_ready_back", cmd_ready, 1'b1)

    // WRITE with delay 3 then READ: 4 idle cycles, busy held until the READ completes
    zero_counters(); rdata_drv = 8'h77;
    expect_req(1'b1, 1'b0, 32'h3000, 8'h11);
    expect_req(1'b0, 1'b0, 32'h3004, 8'h00);
    expect_rsp(32'h3004, 8'h77);
    push_cmd(2'd1, 32'h3000, 8'h11, 8'd3);
    push_cmd(2'd0, 32'h3004, 8'h77, 8'd0);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
      `CHK("t4_busy_hold", busy, 1'b1)
      n++;
    end
    `CHK("t4_rsp_seen", rsp_valid, 1'b1)
    `CHK("t4_busy_end", busy, 1'b0)
    tick(); tick();
    `CHK("t4_gap", last_gap, 4)
    `CHK("t4_issued", issued_cnt, 16'd11)

    // FLUSH, NOP, WRITE
    do_reset(); req_ready = 1'b1; zero_counters();
    expect_req(1'b0, 1'b1, 32'h4000, 8'h00);
    expect_req(1'b1, 1'b0, 32'h4010, 8'h5A);
    push_cmd(2'd2, 32'h4000, 8'h00, 8'd0);
    push_cmd(2'd3, 32'h4008, 8'h00, 8'd0);
    push_cmd(2'd1, 32'h4010, 8'h5A, 8'd0);
    wait_idle(30, "t5_idle");
    tick(); tick();
    `CHK("t5_issued", issued_cnt, 16'd2)
    `CHK("t5_vld_cycles", vld_cycles, 2)
    `CHK("t5_gap", last_gap, 2)
    `CHK("t5_rsp_cycles", rsp_cycles, 0)
    `CHK("t5_sb_empty", exp_req.size(), 0)

    // Reset while a request is in flight with 3 more queued
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(2'd1, 32'h4800 + i, 8'hC0, 8'd0);
    tick();
    `CHK("t6_pre_valid", req_valid, 1'b1)
    rst = 1'b1;
    tick();
    `CHK("t6_valid", req_valid, 1'b0)
    `CHK("t6_busy", busy, 1'b0)
    `CHK("t6_issued", issued_cnt, 16'd0)
    `CHK("t6_cmd_ready", cmd_ready, 1'b1)
    `CHK("t6_req_addr", req_addr, 32'd0)
    rst = 1'b0;
    exp_req.delete(); exp_rsp.delete();
    req_ready = 1'b1; zero_counters();
    repeat (6) tick();
    `CHK("t6_no_req", vld_cycles, 0)
    `CHK("t6_idle", busy, 1'b0)

    // READ returning different data than queued
    zero_counters(); rdata_drv = 8'h54;
    expect_req(1'b0, 1'b0, 32'h5000, 8'h00);
    expect_rsp(32'h5000, 8'h54);
    push_cmd(2'd0, 32'h5000, 8'h55, 8'd0);
    wait_idle(20, "t7_idle");
    tick(); tick();
    `CHK("t7_rsp_cycles", rsp_cycles, 1)
`ifdef CORE_REQ_CHECK_EN
    `CHK("t7_err_cycles", err_cycles, 1)
    `CHK("t7_err_cnt", err_cnt, 16'd1)
`else
    `CHK("t7_err_cycles", err_cycles, 0)
    `CHK("t7_err_cnt", err_cnt, 16'd0)
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_req_engine.md
# core_req_engine

Synthesizable, parametrised core-side request engine that replaces file-driven stimulus with a queued command stream. Commands (read, write, flush-all) are pushed through a valid/ready port into an internal FIFO, then issued one at a time to the cache's core port under a valid/ready handshake. Each command can insert a programmable idle gap after it completes. Read data is returned on a response port. The block sits between a traffic source (testbench sequencer or on-chip generator) and one cache's core-facing interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 8, data width
- DEPTH, 8, command FIFO entries; power of two, ≥2
- DELAY_W, 8, width of per-command post-completion delay
- CNT_W, 16, width of statistics counters

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_op  in  2  0=READ, 1=WRITE, 2=FLUSH, 3=reserved (treated as NOP: popped, not issued)
- cmd_addr  in  ADDR_W  request address
- cmd_data  in  DATA_W  write data; expected read data when checking is compiled in
- cmd_delay  in  DELAY_W  idle cycles inserted after completion
- req_valid  out  1  request to cache
- req_write  out  1  1=write
- req_flush_all  out  1  flush request
- req_addr  out  ADDR_W  request address
- req_wdata  out  DATA_W  write data
- req_ready  in  1  cache accepts/completes request
- req_rdata  in  DATA_W  read data; valid when req_valid & req_ready & !req_write
- rsp_valid  out  1  one-cycle read-return pulse
- rsp_addr  out  ADDR_W  address of returned read
- rsp_rdata  out  DATA_W  returned read data
- busy  out  1  state != IDLE or FIFO non-empty
- issued_cnt  out  CNT_W  completed handshakes, saturating

## Operation
- FSM states:
  - IDLE: FIFO non-empty → pop head. READ/WRITE/FLUSH loads the req_* registers, sets req_valid, goes to ISSUE. NOP goes to IDLE.
  - ISSUE: holds the payload stable. On an edge where req_ready=1, completes the request: clears req_valid and increments issued_cnt. Goes to DELAY if the latched delay is >0, else to IDLE.
  - DELAY: down-counter loaded with cmd_delay. Goes to IDLE on the edge where the counter reaches 1.
- FLUSH drives req_flush_all=1 and req_write=0. Outside ISSUE, req_write, req_flush_all and req_wdata are 0.
- READ completion registers req_rdata and req_addr into rsp_rdata/rsp_addr and pulses rsp_valid for exactly one cycle. There is no response for WRITE or FLUSH.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH; count is CNT-based with an extra bit.
  - Push occurs when cmd_valid & cmd_ready.
  - Push and pop on the same edge leave the count unchanged.
  - cmd_ready is registered-count based and has no same-cycle bypass when full.
- issued_cnt saturates at all-ones.
- Reset mid-operation:
  - On the next edge, all outputs go to 0 and the FSM enters IDLE.
  - FIFO contents, pointers and counters are discarded.
  - An in-flight cache request is abandoned.

## Timing
- Reset values: all outputs 0, except cmd_ready=1.
- Push to req_valid: a command pushed into an empty FIFO at edge E shows req_valid=1 after edge E+1.
- Handshake completes at edge H. req_valid then stays 0 for exactly cmd_delay+1 cycles before the next queued request appears.
- rsp_valid is high for the single cycle following H.
- Back-to-back requests never occur; at least one bubble cycle separates them.

## Configuration
- CORE_REQ_CHECK_EN defined:
  - On READ completion, req_rdata is compared with the command's cmd_data (stored in the FIFO).
  - A mismatch pulses output err_valid for one cycle, concurrent with rsp_valid.
  - A mismatch increments output err_cnt (CNT_W, saturating).
- CORE_REQ_CHECK_EN undefined:
  - cmd_data is ignored for READ.
  - err_valid and err_cnt are tied to 0; the ports still exist.

## Structure
- Package core_req_pkg: opcode enum (READ/WRITE/FLUSH/NOP), FSM state enum, command struct {op, addr, data, delay}.
- Sub-module core_cmd_fifo: parametrised by DEPTH and the struct type; exposes push/pop/full/empty/count.

## Test plan
- WRITE 0x1000/0xA5, delay 0, req_ready tied 1 → req_valid high exactly 1 cycle with req_write=1, addr 0x1000, wdata 0xA5; no rsp_valid; issued_cnt=1.
- READ 0x2004, req_ready held low 5 cycles then high with rdata 0x3C → req_valid high 6 cycles, payload stable throughout; rsp_valid one cycle with rsp_addr 0x2004, rsp_rdata 0x3C.
- DEPTH=8, req_ready held low, push 12 commands → exactly 9 accepted (1 in ISSUE, 8 queued) and cmd_ready low thereafter; after req_ready is released, issue order matches push order.
- WRITE with delay 3 followed by READ → req_valid low exactly 4 cycles between the handshakes; busy stays 1 until the READ completes.
- FLUSH then NOP then WRITE → req_flush_all=1 with req_valid for the FLUSH; NOP produces no request; the WRITE follows after the NOP cycle; issued_cnt=2.
- rst asserted during ISSUE with 3 commands queued → next edge: req_valid=0, busy=0, issued_cnt=0. With CHECK_EN: READ expecting 0x55 returning 0x54 → err_valid pulse, err_cnt=1.
